freepdk45_sram_1rw0r_ctrl: RTL and testbench
============================================

Name: freepdk45_sram_1rw0r_ctrl

Overview:
Initiator-side controller for the single-port 1rw0r OpenRAM macros (default geometry 1024x136, 17-bit write lanes). It converts a valid/ready request stream of reads and lane-masked writes into registered csb0/web0/wmask0/addr0/din0 pin drive. It captures dout0 at the correct edge and returns read data through a credit-limited response FIFO with backpressure. An optional post-reset zero-fill sequencer clears the whole array before normal traffic is accepted.

Parameters:
NUM_WMASKS, 8, number of write-mask lanes
DATA_WIDTH, 136, word width; lane width = DATA_WIDTH/NUM_WMASKS
ADDR_WIDTH, 10, address width; RAM_DEPTH = 1<<ADDR_WIDTH
RSP_DEPTH, 4, response FIFO entries and maximum outstanding reads (min 3 for full read rate)
INIT_ZERO, 1, 1 = zero-fill all words after reset; 0 = skip

Ports:
clk0  in  1  clock, shared with the macro
rst0  in  1  reset, synchronous, active-high
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready at posedge
req_we  in  1  1 = write, 0 = read
req_wmask  in  NUM_WMASKS  lane enables for writes; ignored on reads
req_addr  in  ADDR_WIDTH  word address
req_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  read data valid
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  DATA_WIDTH  read data, FIFO head
init_done  out  1  high once the controller is in RUN
csb0  out  1  macro chip select, active low
web0  out  1  macro write enable, active low
wmask0  out  NUM_WMASKS  macro write mask
addr0  out  ADDR_WIDTH  macro address
din0  out  DATA_WIDTH  macro write data
dout0  in  DATA_WIDTH  macro read data

Behaviour:
- Reset values: csb0=1, web0=1, wmask0=0, addr0=0, din0=0, rsp_valid=0, req_ready=0, init_done=0. FIFO is empty; in-flight and credit counters are 0. The state goes to INIT if INIT_ZERO=1, otherwise to RUN.
- All macro pins are flops updated at posedge clk0; no combinational path from req_* to pins.
- FSM INIT: each cycle drive csb0=0, web0=0, wmask0=all ones, din0=0, addr0 = counter 0..RAM_DEPTH-1. After the write to RAM_DEPTH-1 is driven, go to RUN on the next posedge. req_ready=0 throughout. Full fill takes RAM_DEPTH cycles.
- FSM RUN:
  - init_done=1.
  - req_ready = (outstanding < RSP_DEPTH). outstanding = reads in the 2-stage pipeline plus FIFO occupancy. req_ready is a function of registers only and is independent of req_valid and req_we.
  - On accept at posedge N, the pins carry the request from posedge N to N+1: csb0=0, web0=~req_we, wmask0=req_wmask, addr0, din0.
  - With no accept, csb0=1 and web0=1; wmask0, addr0 and din0 hold their last values.
- Read timing: the macro samples at posedge N+1 and dout0 is valid before posedge N+2. The controller samples dout0 at posedge N+2, pushes it into the FIFO, and rsp_valid can be high from N+2. Read latency is 2 cycles; peak rate is 1 request per cycle.
- Writes produce no response and consume no credit. Write-then-read to the same address on consecutive cycles returns the new data, because the macro writes on the intervening negedge.
- Accepted writes with wmask = 0 are still issued (csb0=0, web0=0); memory is unchanged.
- Responses are returned in request order. A FIFO push and pop in the same cycle leave occupancy unchanged. outstanding increments on read accept and decrements on rsp_valid&rsp_ready; both in one cycle give a net 0.
- rsp_rdata is stable while rsp_valid=1 and rsp_ready=0.
- Reset mid-operation: in-flight reads are dropped and the FIFO is flushed. csb0=1 from the reset posedge onward, and any dout0 returning after reset is ignored. If INIT_ZERO=1, INIT restarts from address 0.

Test Plan:
1. INIT_ZERO=1, release rst0 -> init_done rises after 1024 write cycles, addr0 sweeps 0..1023; a read of addr 0x3FF then returns 136'h0.
2. Write addr 0x005, wmask 8'hFF, data D; read 0x005 on the next cycle -> rsp_valid 2 cycles after the read accept, rsp_rdata = D.
3. Write 0x005 with wmask 8'h01 and data all ones -> the following read returns D with bits [16:0] = 17'h1FFFF and all other bits unchanged.
4. rsp_ready=1, 8 back-to-back reads of 0..7 -> req_ready stays 1, responses on 8 consecutive cycles in order.
5. rsp_ready=0, issue reads -> exactly 4 accepted, req_ready=0. Raise rsp_ready for one cycle -> one pop, one further read accepted; no data lost or reordered.
6. Assert rst0 one cycle after a read accept -> rsp_valid stays 0, csb0=1, and no stale response appears after reset.

Source files
------------

// File: rtl/freepdk45_sram_1rw0r_ctrl.sv
// Initiator-side controller for a single-port 1rw0r OpenRAM macro: registered pin drive,
// two-cycle read capture into a credit-limited response FIFO, optional post-reset zero-fill.
module freepdk45_sram_1rw0r_ctrl #(
  parameter int NUM_WMASKS = 8,
  parameter int DATA_WIDTH = 136,
  parameter int ADDR_WIDTH = 10,
  parameter int RSP_DEPTH  = 4,
  parameter int INIT_ZERO  = 1
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [NUM_WMASKS-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic                  csb0,
  output logic                  web0,
  output logic [NUM_WMASKS-1:0] wmask0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  localparam logic ST_INIT = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic                  state;
  logic [ADDR_WIDTH:0]   init_cnt;
  logic                  rd_p1;
  logic                  rd_p2;
  logic [CNT_W-1:0]      outstanding;
  logic [CNT_W-1:0]      fifo_count;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];

  logic accept;
  logic rd_accept;
  logic push;
  logic pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit check uses registers only, so req_ready never depends on req_valid/req_we.
  assign init_done = (state == ST_RUN);
  assign req_ready = init_done && (outstanding < CNT_W'(RSP_DEPTH));
  assign accept    = req_valid && req_ready;
  assign rd_accept = accept && !req_we;
  assign push      = rd_p2;
  assign rsp_valid = (fifo_count != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_rdata = fifo_mem[rd_ptr];

  // The top bit of init_cnt marks that the last zero-fill write has already been driven.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      state    <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
      init_cnt <= '0;
      csb0     <= 1'b1;
      web0     <= 1'b1;
      wmask0   <= '0;
      addr0    <= '0;
      din0     <= '0;
    end else if (state == ST_INIT) begin
      if (!init_cnt[ADDR_WIDTH]) begin
        csb0     <= 1'b0;
        web0     <= 1'b0;
        wmask0   <= '1;
        din0     <= '0;
        addr0    <= init_cnt[ADDR_WIDTH-1:0];
        init_cnt <= init_cnt + 1'b1;
      end else begin
        csb0  <= 1'b1;
        web0  <= 1'b1;
        state <= ST_RUN;
      end
    end else if (accept) begin
      csb0   <= 1'b0;
      web0   <= ~req_we;
      wmask0 <= req_wmask;
      addr0  <= req_addr;
      din0   <= req_wdata;
    end else begin
      csb0 <= 1'b1;
      web0 <= 1'b1;
    end
  end

  // Read pipeline: pins driven (p1), macro samples (p2), dout0 captured the edge after.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      rd_p1       <= 1'b0;
      rd_p2       <= 1'b0;
      outstanding <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      rd_p1 <= rd_accept;
      rd_p2 <= rd_p1;
      case ({rd_accept, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
    end
  end

  always_ff @(posedge clk0) begin
    if (push) fifo_mem[wr_ptr] <= dout0;
  end

endmodule

// File: tb/tb_freepdk45_sram_1rw0r_ctrl.sv
// Randomised scoreboard bench for freepdk45_sram_1rw0r_ctrl with a behavioural macro
// and a word-level reference memory.
module tb_freepdk45_sram_1rw0r_ctrl;

  localparam int NW    = 8;
  localparam int DW    = 136;
  localparam int AW    = 10;
  localparam int RD    = 4;
  localparam int LW    = DW / NW;
  localparam int DEPTH = 1 << AW;

  logic          clk0 = 1'b0;
  logic          rst0;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [NW-1:0] req_wmask;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic          csb0;
  logic          web0;
  logic [NW-1:0] wmask0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] din0;
  logic [DW-1:0] dout0 = '0;

  freepdk45_sram_1rw0r_ctrl #(
    .NUM_WMASKS(NW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RSP_DEPTH(RD), .INIT_ZERO(1)
  ) dut (
    .clk0(clk0), .rst0(rst0),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_wmask(req_wmask), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0), .dout0(dout0)
  );

  always #5 clk0 = ~clk0;

  // Behavioural macro: latches pins at posedge, writes or reads at the following negedge.
  logic [DW-1:0] macMem [DEPTH];
  logic          latCsb = 1'b1;
  logic          latWeb = 1'b1;
  logic [NW-1:0] latMask;
  logic [AW-1:0] latAddr;
  logic [DW-1:0] latDin;

  always @(posedge clk0) begin
    latCsb  <= csb0;
    latWeb  <= web0;
    latMask <= wmask0;
    latAddr <= addr0;
    latDin  <= din0;
  end

  always @(negedge clk0) begin
    if (!latCsb) begin
      if (!latWeb) begin
        for (int l = 0; l < NW; l++)
          if (latMask[l]) macMem[latAddr][l*LW +: LW] <= latDin[l*LW +: LW];
      end else begin
        dout0 <= macMem[latAddr];
      end
    end
  end

  // Reference model and scoreboard.
  logic [DW-1:0] refMem [DEPTH];
  logic [DW-1:0] expQ [$];
  int            checks = 0;
  int            passes = 0;
  logic          obsRspValid;
  logic          lastAccept;
  int            initWrites;
  int            initAddrExp;
  logic          prevHold = 1'b0;
  logic [DW-1:0] heldData;

  task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] randData();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  task automatic refWrite(input logic [NW-1:0] m, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] bitMask;
    bitMask = '0;
    for (int l = 0; l < NW; l++)
      if (m[l]) bitMask = bitMask | ({{(DW-LW){1'b0}}, {LW{1'b1}}} << (l * LW));
    refMem[a] = (refMem[a] & ~bitMask) | (d & bitMask);
  endtask

  task automatic refZero();
    for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
  endtask

  // One clock of stimulus: drive just after a posedge, sample the handshake at the negedge.
  task automatic applyStimulus(input logic v, input logic we, input logic [NW-1:0] m,
                               input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rr);
    req_valid = v; req_we = we; req_wmask = m; req_addr = a; req_wdata = d; rsp_ready = rr;
    @(negedge clk0);
    obsRspValid = rsp_valid;
    lastAccept  = req_valid && req_ready;
    if (lastAccept && !rst0) begin
      if (we) refWrite(m, a, d);
      else expQ.push_back(refMem[a]);
    end
    @(posedge clk0);
    #1;
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, '0, '0, rr);
  endtask

  task automatic waitInit();
    int n;
    n = 0;
    while (!init_done && n < 3000) begin
      idle(1, 1'b1);
      n++;
    end
    checkOutput("init_done", 160'(init_done), 160'(1));
    checkOutput("init_writes", 160'(initWrites), 160'(DEPTH));
  endtask

  // Monitor: zero-fill sweep, response ordering/data, and data stability under backpressure.
  always @(negedge clk0) begin
    if (rst0) begin
      initAddrExp = 0;
      initWrites  = 0;
      prevHold    = 1'b0;
    end else begin
      if (!init_done && !csb0) begin
        checkOutput("init_pins", {web0, wmask0, addr0, din0},
                    {1'b0, {NW{1'b1}}, AW'(initAddrExp), {DW{1'b0}}});
        initAddrExp++;
        initWrites++;
      end
      if (prevHold) checkOutput("rdata_stable", 160'(rsp_rdata), 160'(heldData));
      if (rsp_valid && rsp_ready) begin
        if (expQ.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_rsp: got rsp_valid=1 with rdata %h, required no response", rsp_rdata);
        end else begin
          checkOutput("rsp_rdata", 160'(rsp_rdata), 160'(expQ.pop_front()));
        end
      end
      prevHold = rsp_valid && !rsp_ready;
      heldData = rsp_rdata;
    end
  end

  initial begin
    int acc;
    logic [DW-1:0] dWord;
    logic [2:0] lat;

    for (int i = 0; i < DEPTH; i++) macMem[i] = randData();
    refZero();
    rst0 = 1'b1;
    idle(3, 1'b1);
    checkOutput("reset_pins", {csb0, web0, wmask0, addr0, din0}, {2'b11, {(NW+AW+DW){1'b0}}});
    checkOutput("reset_flags", 160'({rsp_valid, req_ready, init_done}), 160'(0));

    // Zero-fill then read the last word.
    rst0 = 1'b0;
    waitInit();
    applyStimulus(1'b1, 1'b0, '0, 10'h3FF, '0, 1'b1);
    checkOutput("read_3ff_accept", 160'(lastAccept), 160'(1));
    idle(4, 1'b1);

    // Full write then read-after-write with latency check.
    dWord = randData();
    applyStimulus(1'b1, 1'b1, 8'hFF, 10'h005, dWord, 1'b0);
    checkOutput("wr_accept", 160'(lastAccept), 160'(1));
    applyStimulus(1'b1, 1'b0, '0, 10'h005, '0, 1'b0);
    checkOutput("rd_accept", 160'(lastAccept), 160'(1));
    for (int i = 0; i < 3; i++) begin
      idle(1, 1'b0);
      lat[i] = obsRspValid;
    end
    checkOutput("read_latency", 160'(lat), 160'(3'b100));
    idle(3, 1'b1);

    // Single-lane write of all ones.
    applyStimulus(1'b1, 1'b1, 8'h01, 10'h005, {DW{1'b1}}, 1'b1);
    applyStimulus(1'b1, 1'b0, '0, 10'h005, '0, 1'b1);
    idle(4, 1'b1);

    // Back-to-back reads at full rate.
    for (int j = 0; j < 13; j++) begin
      if (j < 8) begin
        applyStimulus(1'b1, 1'b0, '0, AW'(j), '0, 1'b1);
        checkOutput("b2b_accept", 160'(lastAccept), 160'(1));
      end else begin
        idle(1, 1'b1);
      end
      checkOutput("b2b_rsp_valid", 160'(obsRspValid), 160'((j >= 3 && j <= 10) ? 1 : 0));
    end

    // Credit limit under backpressure.
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, '0, AW'(8 + i), '0, 1'b0);
      if (lastAccept) acc++;
    end
    checkOutput("credit_accepts", 160'(acc), 160'(RD));
    checkOutput("credit_ready_low", 160'(req_ready), 160'(0));
    applyStimulus(1'b1, 1'b0, '0, 10'd20, '0, 1'b1);
    checkOutput("credit_pop_cycle", 160'(lastAccept), 160'(0));
    applyStimulus(1'b1, 1'b0, '0, 10'd21, '0, 1'b0);
    checkOutput("credit_refill", 160'(lastAccept), 160'(1));
    applyStimulus(1'b1, 1'b0, '0, 10'd22, '0, 1'b0);
    checkOutput("credit_full_again", 160'(lastAccept), 160'(0));
    idle(8, 1'b1);
    checkOutput("credit_drained", 160'(expQ.size()), 160'(0));

    // Reset one cycle after a read accept.
    applyStimulus(1'b1, 1'b0, '0, 10'd3, '0, 1'b1);
    rst0 = 1'b1;
    expQ.delete();
    refZero();
    idle(2, 1'b1);
    checkOutput("rst_mid_pins", 160'({csb0, rsp_valid, req_ready}), 160'(3'b100));
    rst0 = 1'b0;
    waitInit();

    // Random traffic over a small address window.
    for (int i = 0; i < 400; i++) begin
      logic [NW-1:0] m;
      m = ($urandom_range(0, 7) == 0) ? '0 : NW'($urandom);
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, m,
                    AW'($urandom_range(0, 15)), randData(), $urandom_range(0, 3) != 0);
    end
    idle(10, 1'b1);
    checkOutput("final_drained", 160'(expQ.size()), 160'(0));

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
